note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Controller that sequences one synth voice: phase accumulator, scaler/summer, sample buffer.
- Turns CPU MMIO pulses (note_start, note_release, note_reset) into a note lifecycle FSM.
- Generates the sample-rate tick and runs a valid/ready handshake with the sample buffer.
- Drives a release-envelope attenuation shift and reports note_finished back to the MMIO read path.

Parameters:
CPU_CLOCK_FREQ, 125_000_000, clk frequency in Hz
SAMPLE_RATE, 30_000, audio sample rate in Hz; TICK_DIV = CPU_CLOCK_FREQ / SAMPLE_RATE (integer division, must be >= 2)
RELEASE_SAMPLES, 4096, release length in samples; power of two, >= 16
FCW_WIDTH, 24, frequency control word width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
note_start  in  1  one-cycle pulse: begin or retrigger note
note_release  in  1  one-cycle pulse: begin release
note_reset  in  1  one-cycle pulse: abort to IDLE
fcw_in  in  FCW_WIDTH  FCW register value; sampled on note_start
fcw_out  out  FCW_WIDTH  latched FCW for the phase accumulator
accum_clear  out  1  one-cycle pulse: zero the accumulator
accum_step  out  1  one-cycle pulse: advance the accumulator by fcw_out
sample_valid  out  1  sample request to the buffer
sample_ready  in  1  buffer accepts the sample
release_shift  out  5  extra right-shift attenuation, 0..16
note_finished  out  1  level: release completed
state  out  2  FSM state: 0 IDLE, 1 PLAY, 2 RELEASE, 3 DONE
overrun_count  out  16  missed-tick counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state=IDLE; tick counter=0; release counter=0.
- Tick counter:
  - Free-runs 0..TICK_DIV-1.
  - tick=1 on the cycle it equals TICK_DIV-1, then wraps to 0.
  - Runs in every state; is not reset by note events.
- Handshake:
  - On tick in PLAY or RELEASE with sample_valid=0, sample_valid rises the next cycle.
  - Held high until a cycle with sample_valid && sample_ready; falls the following cycle.
  - accum_step pulses for exactly one cycle, registered, the cycle after each handshake.
  - Tick while sample_valid is still high = overrun: no second request is queued.
- FSM (event priority: note_reset > note_start > note_release):
  - IDLE: start -> PLAY. release is ignored.
  - PLAY: start -> PLAY (retrigger); release -> RELEASE, release counter loads RELEASE_SAMPLES.
  - RELEASE: each handshake decrements the counter. Counter 1 -> 0 on a handshake -> DONE. start -> PLAY.
  - DONE: note_finished=1. No requests issued. start -> PLAY. release is ignored.
  - Any state: reset -> IDLE. Clears note_finished, sample_valid, release_shift and the release counter; fcw_out is retained.
- On note_start (any state):
  - fcw_out <= fcw_in.
  - accum_clear pulses the next cycle.
  - release_shift <= 0; note_finished <= 0.
  - A pending sample_valid stays high until its handshake.
- release_shift:
  - 0 in PLAY.
  - In RELEASE: (RELEASE_SAMPLES - counter) / (RELEASE_SAMPLES/16), so 0..15.
  - 16 in DONE.
  - Updated combinationally from the registered counter.
- Leaving PLAY/RELEASE with sample_valid high (reset only) drops sample_valid immediately; no accum_step follows.

Optional Feature:
- Macro: NOTE_SEQUENCER_OVERRUN_CNT_EN.
- Defined:
  - overrun_count increments on each overrun, saturating at 16'hFFFF.
  - Cleared by rst or note_reset.
- Undefined: overrun_count is tied to 0 and no counter logic is built.

Decomposition:
- Shared package synth_pkg holds:
  - state encoding constants: NOTE_IDLE, NOTE_PLAY, NOTE_RELEASE, NOTE_DONE;
  - the release_shift maximum (16);
  - the FCW_WIDTH default.
- Sub-module sample_tick_gen: parameterized TICK_DIV divider with a tick output. All other logic stays in note_sequencer.

Test Plan:
All cases use CPU_CLOCK_FREQ=1000, SAMPLE_RATE=100 (TICK_DIV=10), RELEASE_SAMPLES=32.
1. Reset then start with fcw_in=24'h00_1000, sample_ready tied 1:
   - fcw_out=24'h001000, accum_clear one pulse;
   - sample_valid every 10 cycles; accum_step one cycle after each.
2. Release after 5 samples, ready=1:
   - state=2;
   - release_shift steps 0,1,...,15 every 2 samples;
   - after 32 handshakes state=3, note_finished=1, release_shift=16, no further sample_valid.
3. Hold sample_ready=0 for 25 cycles during PLAY:
   - sample_valid stays high;
   - overrun_count=2 with the macro defined, 0 without;
   - only one accum_step after ready rises.
4. Same-cycle note_reset and note_start in RELEASE -> state=0, note_finished=0, no accum_clear.
5. note_start during RELEASE with fcw_in=24'h00_2000 -> state=1, release_shift=0, fcw_out=24'h002000.
6. Assert rst asynchronously mid-handshake -> all outputs 0 in the same cycle, state=0; the tick phase restarts from 0.

Source files
------------

// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
//   Shared definitions for the synth voice blocks.
//   - note_state_e      : note lifecycle state encoding (visible on the
//                         sequencer's 2-bit state output)
//   - RELEASE_SHIFT_MAX : attenuation shift applied once a release has
//                         fully decayed
//   - FCW_WIDTH_DEFAULT : default width of the frequency control word
// ---------------------------------------------------------------------------
package synth_pkg;

  typedef enum logic [1:0] {
    NOTE_IDLE    = 2'd0,
    NOTE_PLAY    = 2'd1,
    NOTE_RELEASE = 2'd2,
    NOTE_DONE    = 2'd3
  } note_state_e;

  localparam logic [4:0] RELEASE_SHIFT_MAX = 5'd16;

  localparam int FCW_WIDTH_DEFAULT = 24;

endpackage : synth_pkg

// File: rtl/sample_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
//   Free-running divider that produces the audio sample-rate tick.
//   The counter runs 0..TICK_DIV-1 and wraps; tick is high for the single
//   cycle in which the counter holds TICK_DIV-1.
//
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (counter returns to 0)
//   tick out one-cycle pulse every TICK_DIV cycles
// ---------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every signal written in an always_comb gets a value before any
  // branch, so no path can leave it holding its old value (which would
  // infer a latch).
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // that every flop samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sample_tick_gen

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//   Sequences one synth voice. CPU register pulses drive a note lifecycle
//   FSM (IDLE -> PLAY -> RELEASE -> DONE); a sample-rate tick paces a
//   valid/ready request to the sample buffer; each accepted sample advances
//   the phase accumulator; a release counter drives a stepped attenuation
//   shift during the release phase.
//
// Optional feature (macro NOTE_SEQUENCER_OVERRUN_CNT_EN):
//   defined   : overrun_count counts ticks that arrive while a request is
//               still pending, saturating at 16'hFFFF; cleared by rst or
//               note_reset.
//   undefined : overrun_count is tied to 0.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   note_start      pulse: start or retrigger the note (latches fcw_in)
//   note_release    pulse: enter release (only from PLAY)
//   note_reset      pulse: abort to IDLE (highest priority)
//   fcw_in          frequency control word, sampled on note_start
//   fcw_out         latched frequency control word
//   accum_clear     pulse the cycle after an accepted note_start
//   accum_step      pulse the cycle after each sample handshake
//   sample_valid    sample request to the buffer
//   sample_ready    buffer accepts the request
//   release_shift   extra right-shift attenuation 0..16
//   note_finished   high while the note sits in DONE
//   state           FSM state (0 IDLE, 1 PLAY, 2 RELEASE, 3 DONE)
//   overrun_count   missed-tick counter (see optional feature)
// ---------------------------------------------------------------------------
module note_sequencer
  import synth_pkg::*;
#(
  parameter int CPU_CLOCK_FREQ  = 125_000_000,
  parameter int SAMPLE_RATE     = 30_000,
  parameter int RELEASE_SAMPLES = 4096,
  parameter int FCW_WIDTH       = FCW_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 note_start,
  input  logic                 note_release,
  input  logic                 note_reset,
  input  logic [FCW_WIDTH-1:0] fcw_in,
  output logic [FCW_WIDTH-1:0] fcw_out,
  output logic                 accum_clear,
  output logic                 accum_step,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [4:0]           release_shift,
  output logic                 note_finished,
  output logic [1:0]           state,
  output logic [15:0]          overrun_count
);

  localparam int TICK_DIV = CPU_CLOCK_FREQ / SAMPLE_RATE;
  // One extra bit so the counter can hold RELEASE_SAMPLES itself.
  localparam int RC_W     = $clog2(RELEASE_SAMPLES) + 1;
  // release_shift advances once every RELEASE_SAMPLES/16 samples.
  localparam int SEG_SHIFT = $clog2(RELEASE_SAMPLES) - 4;
  localparam logic [RC_W-1:0] REL_LOAD = RC_W'(RELEASE_SAMPLES);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("note_sequencer: CPU_CLOCK_FREQ / SAMPLE_RATE must be at least 2");
  end
  if ((RELEASE_SAMPLES < 16) ||
      ((RELEASE_SAMPLES & (RELEASE_SAMPLES - 1)) != 0)) begin : g_bad_release
    $error("note_sequencer: RELEASE_SAMPLES must be a power of two >= 16");
  end

  // -------------------------------------------------------------------------
  // Sample-rate tick
  // -------------------------------------------------------------------------
  logic tick;

  sample_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  note_state_e            state_q,        state_d;
  logic [RC_W-1:0]        rel_cnt_q,      rel_cnt_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   accum_step_q,   accum_step_d;
  logic                   accum_clear_q,  accum_clear_d;
  logic [FCW_WIDTH-1:0]   fcw_q,          fcw_d;

  logic handshake;
  logic start_evt;
  logic voice_active;

  assign handshake    = sample_valid_q && sample_ready;
  // note_reset outranks note_start; a start in the same cycle is dropped.
  assign start_evt    = note_start && !note_reset;
  assign voice_active = (state_q == NOTE_PLAY) || (state_q == NOTE_RELEASE);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NOTE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (note_reset) begin
      state_d = NOTE_IDLE;
    end else if (note_start) begin
      state_d = NOTE_PLAY;
    end else begin
      case (state_q)
        NOTE_PLAY: begin
          if (note_release) begin
            state_d = NOTE_RELEASE;
          end
        end
        NOTE_RELEASE: begin
          // The handshake that takes the counter from 1 to 0 ends the release.
          if (handshake && (rel_cnt_q == RC_W'(1))) begin
            state_d = NOTE_DONE;
          end
        end
        default: begin
          // IDLE and DONE only leave on note_start / note_reset.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (derived from registered state and counter)
  // -------------------------------------------------------------------------
  always_comb begin
    release_shift = '0;
    note_finished = 1'b0;
    case (state_q)
      NOTE_RELEASE: release_shift = 5'((REL_LOAD - rel_cnt_q) >> SEG_SHIFT);
      NOTE_DONE: begin
        release_shift = RELEASE_SHIFT_MAX;
        note_finished = 1'b1;
      end
      default: begin
        release_shift = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: FCW latch, accumulator pulses, request handshake, release count
  // -------------------------------------------------------------------------
  always_comb begin
    fcw_d          = fcw_q;
    accum_clear_d  = start_evt;
    // An aborting note_reset suppresses the step for a coincident handshake.
    accum_step_d   = handshake && !note_reset;
    sample_valid_d = sample_valid_q;
    rel_cnt_d      = rel_cnt_q;

    if (start_evt) begin
      fcw_d = fcw_in;
    end

    // A pending request survives a retrigger; only its handshake or an
    // abort lowers it. A tick while it is still high is an overrun and does
    // not queue a second request.
    if (note_reset || handshake) begin
      sample_valid_d = 1'b0;
    end else if (tick && voice_active && !sample_valid_q) begin
      sample_valid_d = 1'b1;
    end

    if (note_reset) begin
      rel_cnt_d = '0;
    end else if (!note_start) begin
      if ((state_q == NOTE_PLAY) && note_release) begin
        rel_cnt_d = REL_LOAD;
      end else if ((state_q == NOTE_RELEASE) && handshake) begin
        rel_cnt_d = rel_cnt_q - RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcw_q          <= '0;
      accum_clear_q  <= 1'b0;
      accum_step_q   <= 1'b0;
      sample_valid_q <= 1'b0;
      rel_cnt_q      <= '0;
    end else begin
      fcw_q          <= fcw_d;
      accum_clear_q  <= accum_clear_d;
      accum_step_q   <= accum_step_d;
      sample_valid_q <= sample_valid_d;
      rel_cnt_q      <= rel_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Optional overrun counter
  // -------------------------------------------------------------------------
`ifdef NOTE_SEQUENCER_OVERRUN_CNT_EN
  logic [15:0] overrun_q;
  logic [15:0] overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (note_reset) begin
      overrun_d = '0;
    end else if (tick && sample_valid_q && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_count = overrun_q;
`else
  assign overrun_count = '0;
`endif

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign fcw_out      = fcw_q;
  assign accum_clear  = accum_clear_q;
  assign accum_step   = accum_step_q;
  assign sample_valid = sample_valid_q;
  assign state        = state_q;

endmodule : note_sequencer

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
//   Directed bench for note_sequencer with TICK_DIV=10, RELEASE_SAMPLES=32.
//   Inputs change 1 time unit after a rising edge and outputs are sampled
//   there too. cyc counts rising edges since the last reset release, so the
//   divider holds cyc % 10 and ticks while cyc % 10 == 9; a request raised
//   by that tick is visible at the next phase 0.
// ---------------------------------------------------------------------------
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        note_start = 1'b0;
  logic        note_release = 1'b0;
  logic        note_reset = 1'b0;
  logic [23:0] fcw_in = '0;
  logic [23:0] fcw_out;
  logic        accum_clear;
  logic        accum_step;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic [4:0]  release_shift;
  logic        note_finished;
  logic [1:0]  state;
  logic [15:0] overrun_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  note_sequencer #(
    .CPU_CLOCK_FREQ  (1000),
    .SAMPLE_RATE     (100),
    .RELEASE_SAMPLES (32),
    .FCW_WIDTH       (24)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .note_start    (note_start),
    .note_release  (note_release),
    .note_reset    (note_reset),
    .fcw_in        (fcw_in),
    .fcw_out       (fcw_out),
    .accum_clear   (accum_clear),
    .accum_step    (accum_step),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .release_shift (release_shift),
    .note_finished (note_finished),
    .state         (state),
    .overrun_count (overrun_count)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the divider phase equals ph (at most one full period).
  task automatic goto_phase(input int ph);
    for (int i = 0; i < 10; i++) begin
      if ((cyc % 10) == ph) break;
      step();
    end
  endtask

  // One sample with sample_ready=1: idle before the tick, request at
  // phase 0, accepted in that cycle, accumulator step at phase 1.
  task automatic expect_sample(input string tag);
    goto_phase(9);
    check({tag, " valid before tick"}, 32'(sample_valid), 32'd0);
    step();
    check({tag, " valid after tick"}, 32'(sample_valid), 32'd1);
    check({tag, " no early step"}, 32'(accum_step), 32'd0);
    step();
    check({tag, " valid dropped"}, 32'(sample_valid), 32'd0);
    check({tag, " accum_step"}, 32'(accum_step), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, 32'(state), 32'd0);
    check({tag, " fcw_out"}, 32'(fcw_out), 32'd0);
    check({tag, " accum_clear"}, 32'(accum_clear), 32'd0);
    check({tag, " accum_step"}, 32'(accum_step), 32'd0);
    check({tag, " sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, " release_shift"}, 32'(release_shift), 32'd0);
    check({tag, " note_finished"}, 32'(note_finished), 32'd0);
    check({tag, " overrun_count"}, 32'(overrun_count), 32'd0);
  endtask

  initial begin
    int seen;
    int exp_ovr;
`ifdef NOTE_SEQUENCER_OVERRUN_CNT_EN
    exp_ovr = 2;
`else
    exp_ovr = 0;
`endif

    // ---- Reset state ----
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    cyc = 0;

    // ---- 1: start, fcw latch, clear pulse, periodic requests ----
    step(); step(); step();                      // cyc 3
    note_start = 1'b1;
    fcw_in     = 24'h00_1000;
    step();                                      // cyc 4
    note_start = 1'b0;
    check("t1 state play", 32'(state), 32'd1);
    check("t1 fcw_out", 32'(fcw_out), 32'h1000);
    check("t1 accum_clear pulse", 32'(accum_clear), 32'd1);
    step();                                      // cyc 5
    check("t1 accum_clear ends", 32'(accum_clear), 32'd0);
    for (int k = 1; k <= 5; k++) expect_sample("t1 sample");  // ends cyc 51

    // ---- 2: release ramp down to DONE ----
    note_release = 1'b1;
    step();                                      // cyc 52
    note_release = 1'b0;
    check("t2 state release", 32'(state), 32'd2);
    check("t2 shift start", 32'(release_shift), 32'd0);
    for (int i = 1; i <= 32; i++) begin
      expect_sample("t2 release sample");
      if (i < 32) begin
        check("t2 state mid", 32'(state), 32'd2);
        check("t2 shift step", 32'(release_shift), 32'(i / 2));
      end else begin
        check("t2 state done", 32'(state), 32'd3);
        check("t2 note_finished", 32'(note_finished), 32'd1);
        check("t2 shift max", 32'(release_shift), 32'd16);
      end
    end                                          // cyc 371
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (sample_valid !== 1'b0) seen++;
    end                                          // cyc 396
    check("t2 no request in done", 32'(seen), 32'd0);
    check("t2 finished held", 32'(note_finished), 32'd1);

    // ---- 3: stalled buffer, overruns, single step ----
    note_start = 1'b1;
    fcw_in     = 24'h00_1000;
    step();                                      // cyc 397
    note_start = 1'b0;
    check("t3 state play", 32'(state), 32'd1);
    check("t3 finished cleared", 32'(note_finished), 32'd0);
    check("t3 shift cleared", 32'(release_shift), 32'd0);
    goto_phase(9);                               // cyc 399
    sample_ready = 1'b0;
    step();                                      // cyc 400
    check("t3 valid raised", 32'(sample_valid), 32'd1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (sample_valid !== 1'b1 || accum_step !== 1'b0) seen++;
    end                                          // cyc 425
    check("t3 valid held no step", 32'(seen), 32'd0);
    check("t3 overrun_count", 32'(overrun_count), 32'(exp_ovr));
    sample_ready = 1'b1;
    step();                                      // cyc 426
    check("t3 valid dropped", 32'(sample_valid), 32'd0);
    check("t3 accum_step", 32'(accum_step), 32'd1);
    step();                                      // cyc 427
    check("t3 single step", 32'(accum_step), 32'd0);
    check("t3 overrun kept", 32'(overrun_count), 32'(exp_ovr));

    // ---- 4: reset + start together in RELEASE with a pending request ----
    note_release = 1'b1;
    step();                                      // cyc 428
    note_release = 1'b0;
    sample_ready = 1'b0;
    check("t4 state release", 32'(state), 32'd2);
    step(); step();                              // cyc 430
    check("t4 pending valid", 32'(sample_valid), 32'd1);
    note_reset = 1'b1;
    note_start = 1'b1;
    fcw_in     = 24'h00_3000;
    step();                                      // cyc 431
    note_reset = 1'b0;
    note_start = 1'b0;
    check("t4 state idle", 32'(state), 32'd0);
    check("t4 note_finished", 32'(note_finished), 32'd0);
    check("t4 no accum_clear", 32'(accum_clear), 32'd0);
    check("t4 valid dropped", 32'(sample_valid), 32'd0);
    check("t4 fcw retained", 32'(fcw_out), 32'h1000);
    check("t4 overrun cleared", 32'(overrun_count), 32'd0);
    sample_ready = 1'b1;
    step();                                      // cyc 432
    check("t4 no accum_step", 32'(accum_step), 32'd0);

    // ---- 5: retrigger during RELEASE ----
    note_start = 1'b1;
    fcw_in     = 24'h00_1000;
    step();                                      // cyc 433
    note_start   = 1'b0;
    note_release = 1'b1;
    step();                                      // cyc 434
    note_release = 1'b0;
    check("t5 state release", 32'(state), 32'd2);
    for (int k = 1; k <= 4; k++) expect_sample("t5 sample");  // cyc 471
    check("t5 shift after 4", 32'(release_shift), 32'd2);
    note_start = 1'b1;
    fcw_in     = 24'h00_2000;
    step();                                      // cyc 472
    note_start = 1'b0;
    check("t5 state play", 32'(state), 32'd1);
    check("t5 shift zero", 32'(release_shift), 32'd0);
    check("t5 fcw_out", 32'(fcw_out), 32'h2000);
    check("t5 accum_clear", 32'(accum_clear), 32'd1);

    // ---- 6: asynchronous reset mid-handshake ----
    sample_ready = 1'b0;
    goto_phase(0);                               // cyc 480
    check("t6 valid pending", 32'(sample_valid), 32'd1);
    for (int i = 0; i < 5; i++) step();          // cyc 485, divider at 5
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6 async reset");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    cyc          = 0;
    sample_ready = 1'b1;
    note_start   = 1'b1;
    fcw_in       = 24'h00_0800;
    step();                                      // cyc 1
    note_start = 1'b0;
    check("t6 restart play", 32'(state), 32'd1);
    check("t6 restart fcw", 32'(fcw_out), 32'h0800);
    expect_sample("t6 tick phase restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_note_sequencer
